snake_grid: RTL

Parametrised snake-body occupancy grid: holds one bit per board cell, applies one head-advance/tail-retract step per handshake, and detects food, growth and self/wall collision. Successor to the fixed 16×8 pixel generator. Sits between the movement controller, which supplies head/tail/food positions, and the display scanner, which reads `grid_o`.

---
 rtl/snake_grid.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/snake_grid.sv
// ============================================================================
// Module      : snake_grid
// Description : Snake-body occupancy grid. One bit per board cell; each
//               accepted step retracts the tail and advances the head, with
//               food/growth detection and optional self/wall collision.
//               Optional feature macro: SNAKE_GRID_COLLIDE_EN (collision
//               detection and sticky collide_o; undefined ties collide_o low).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module snake_grid #(
   parameter  int COL_W    = 4,
   parameter  int ROWS     = 8,
   parameter  int INIT_LEN = 3,
   localparam int COLS     = 2 ** COL_W,
   localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int HW       = ROW_W + COL_W,
   localparam int CELLS    = ROWS * COLS,
   localparam int LEN_W    = $clog2(CELLS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             init_i,
   input  logic             step_valid_i,
   output logic             step_ready_o,
   input  logic [HW-1:0]    head_i,
   input  logic [HW-1:0]    tail_i,
   input  logic [HW-1:0]    food_i,
   output logic [CELLS-1:0] grid_o,
   output logic [LEN_W-1:0] length_o,
   output logic             grow_o,
   output logic             done_o,
   output logic             collide_o
);

   localparam logic [ROW_W:0]   ROWS_X   = ROWS[ROW_W:0];
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(CELLS);
   localparam logic [LEN_W-1:0] LEN_INIT = LEN_W'(INIT_LEN);

   typedef enum logic [2:0] {
      S_CLEAR = 3'd0,
      S_SEED  = 3'd1,
      S_IDLE  = 3'd2,
      S_CHECK = 3'd3,
      S_WRITE = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_nx;
   logic [CELLS-1:0]    r_grid;
   logic [LEN_W-1:0]    r_length;
   logic                r_grow;
   logic                r_done;
   logic [ROW_W-1:0]    r_rowcnt;
   logic [HW-1:0]       r_head;
   logic [HW-1:0]       r_tail;
   logic [HW-1:0]       r_food;
   logic                r_eat;
   logic                w_ready;
   logic                w_accept;
   logic                w_head_inr;
   logic                w_tail_inr;
   logic                w_blocked;

   assign w_ready    = (r_state == S_IDLE) && !init_i;
   assign w_accept   = step_valid_i && w_ready;
   // Cell index is simply {row,col}; a row at or beyond ROWS is off the board.
   assign w_head_inr = {1'b0, r_head[HW-1:COL_W]} < ROWS_X;
   assign w_tail_inr = {1'b0, r_tail[HW-1:COL_W]} < ROWS_X;

`ifdef SNAKE_GRID_COLLIDE_EN
   logic r_hit;
   logic r_collide;
   logic w_head_occ;
   logic w_hit;

   assign w_head_occ = w_head_inr && r_grid[r_head];
   // Moving onto the cell the tail is leaving is legal unless the snake grows.
   assign w_hit      = !w_head_inr ||
                       (w_head_occ && ((r_head != r_tail) || (r_head == r_food)));
   assign w_blocked  = r_hit || r_collide;
   assign collide_o  = r_collide;

   // Latch the collision verdict in CHECK; sticky flag set in WRITE, cleared by init.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hit     <= 1'b0;
         r_collide <= 1'b0;
      end else if (init_i) begin
         r_collide <= 1'b0;
      end else if (r_state == S_CHECK) begin
         r_hit <= w_hit;
      end else if (r_state == S_WRITE && w_blocked) begin
         r_collide <= 1'b1;
      end
   end
`else
   assign w_blocked = 1'b0;
   assign collide_o = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_SEED;
      else     r_state <= w_state_nx;
   end

   // Next-state logic; a restart request overrides every state.
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_CLEAR: if (r_rowcnt == ROW_LAST) w_state_nx = S_SEED;
         S_SEED:  w_state_nx = S_IDLE;
         S_IDLE:  if (w_accept) w_state_nx = S_CHECK;
         S_CHECK: w_state_nx = S_WRITE;
         S_WRITE: w_state_nx = S_IDLE;
         default: w_state_nx = S_SEED;
      endcase
      if (init_i) w_state_nx = S_CLEAR;
   end

   // Grid, length, pulses and latched step operands.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_grid   <= '0;
         r_length <= '0;
         r_grow   <= 1'b0;
         r_done   <= 1'b0;
         r_rowcnt <= '0;
         r_head   <= '0;
         r_tail   <= '0;
         r_food   <= '0;
         r_eat    <= 1'b0;
      end else begin
         r_grow <= 1'b0;
         r_done <= 1'b0;
         if (init_i) begin
            r_rowcnt <= '0;
         end else begin
            case (r_state)
               S_CLEAR: begin
                  for (int c = 0; c < COLS; c++) r_grid[{r_rowcnt, COL_W'(c)}] <= 1'b0;
                  r_rowcnt <= r_rowcnt + 1'b1;
               end
               S_SEED: begin
                  for (int c = 0; c < INIT_LEN; c++) r_grid[c] <= 1'b1;
                  r_length <= LEN_INIT;
               end
               S_IDLE: begin
                  if (w_accept) begin
                     r_head <= head_i;
                     r_tail <= tail_i;
                     r_food <= food_i;
                  end
               end
               S_CHECK: r_eat <= (r_head == r_food);
               S_WRITE: begin
                  r_done <= 1'b1;
                  if (!w_blocked) begin
                     // Head set after tail clear so head==tail keeps the cell.
                     if (!r_eat && w_tail_inr) r_grid[r_tail] <= 1'b0;
                     if (w_head_inr)           r_grid[r_head] <= 1'b1;
                     if (r_eat) begin
                        r_grow <= 1'b1;
                        if (r_length != LEN_MAX) r_length <= r_length + 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign step_ready_o = w_ready;
   assign grid_o       = r_grid;
   assign length_o     = r_length;
   assign grow_o       = r_grow;
   assign done_o       = r_done;

endmodule

`default_nettype wire
